// File: rtl/quadenc_pkg.sv
// Shared types and constants for the quadrature encoder counter with index support.
package quadenc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        CAPTURED = 2'd2
    } idx_state_e;

    localparam int QUAD_X4 = 0;
    localparam int QUAD_X2 = 1;
    localparam int QUAD_X1 = 2;

    localparam int FILT_W = 8;

endpackage

// File: rtl/quadenc_filter.sv
// Two-flop synchroniser followed by a stability filter: the output follows the
// synchronised input only after it has differed for FILTER_LEN consecutive cycles.
module quadenc_filter
    import quadenc_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [FILT_W-1:0] LAST = FILT_W'(FILTER_LEN - 1);

    logic              sync1;
    logic              sync2;
    logic [FILT_W-1:0] fcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            fcnt  <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                fcnt <= '0;
            end else if (fcnt == LAST) begin
                dout <= sync2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quadencoderz_filt.sv
// Filtered quadrature counter with index arming/capture, preset load and a sticky
// illegal-transition flag.
module quadencoderz_filt
    import quadenc_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int QUAD_TYPE  = QUAD_X4,
    parameter int FILTER_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a,
    input  logic                   b,
    input  logic                   z,
    input  logic                   indexenable,
    input  logic                   cntreset,
    input  logic                   load,
    input  logic signed [BITS-1:0] preset,
    input  logic                   err_clr,
    output logic                   indexout,
    output logic signed [BITS-1:0] index_pos,
    output logic signed [BITS-1:0] position,
    output logic                   direction,
    output logic                   quad_err
);

    localparam logic signed [BITS-1:0] ONE   = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic signed [BITS-1:0] M_ONE = {BITS{1'b1}};

    logic fa, fb, fz;
    logic ap, bp, zp;
    logic step, up, err_evt, zrise, capture;
    logic signed [BITS-1:0] count;
    logic signed [BITS-1:0] count_nxt;
    idx_state_e state;

    quadenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .rst_n(rst_n), .din(a), .dout(fa));
    quadenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .rst_n(rst_n), .din(b), .dout(fb));
    quadenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (.clk(clk), .rst_n(rst_n), .din(z), .dout(fz));

    assign step     = (fa ^ ap) ^ (fb ^ bp);
    assign up       = fa ^ bp;
    assign err_evt  = (fa ^ ap) & (fb ^ bp);
    assign zrise    = fz & ~zp;
    assign capture  = (state == ARMED) && zrise;
    assign position = count >>> QUAD_TYPE;

    // Load beats an index reset, which beats a plain step; a step coincident with
    // an index reset still counts from zero.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = preset;
        end else if (capture && cntreset) begin
            count_nxt = step ? (up ? ONE : M_ONE) : '0;
        end else if (step) begin
            count_nxt = up ? count + ONE : count - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap        <= 1'b0;
            bp        <= 1'b0;
            zp        <= 1'b0;
            count     <= '0;
            direction <= 1'b0;
            quad_err  <= 1'b0;
        end else begin
            ap    <= fa;
            bp    <= fb;
            zp    <= fz;
            count <= count_nxt;
            if (step && !load) begin
                direction <= up;
            end
            if (err_evt) begin
                quad_err <= 1'b1;
            end else if (err_clr) begin
                quad_err <= 1'b0;
            end
        end
    end

    // Index arming FSM; capture takes precedence over disarm in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            indexout  <= 1'b0;
            index_pos <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (indexenable) begin
                        state    <= ARMED;
                        indexout <= 1'b1;
                    end
                end
                ARMED: begin
                    if (zrise) begin
                        state     <= CAPTURED;
                        indexout  <= 1'b0;
                        index_pos <= position;
                    end else if (!indexenable) begin
                        state    <= IDLE;
                        indexout <= 1'b0;
                    end
                end
                CAPTURED: begin
                    if (!indexenable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    indexout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quadencoderz_filt.sv
// Scoreboard bench: two instances (32-bit x4 and 8-bit x1) share the pins; expected
// output snapshots are queued by the stimulus and compared by a separate monitor.
module tb_quadencoderz_filt;

    typedef struct {
        string  name;
        longint pos;
        longint pos8;
        bit     dir;
        bit     err;
        bit     iout;
        longint ipos;
        longint ipos8;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0, z = 1'b0;
    logic indexenable = 1'b0, cntreset = 1'b0, load = 1'b0, err_clr = 1'b0;
    logic signed [31:0] preset = '0;
    logic signed [7:0]  preset8 = '0;

    logic               indexout, direction, quad_err;
    logic signed [31:0] index_pos, position;
    logic               indexout8, direction8, quad_err8;
    logic signed [7:0]  index_pos8, position8;

    int   total = 0;
    int   bad = 0;
    int   req_cnt = 0;
    int   ph = 0;
    exp_t sb[$];
    logic [1:0] phase_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quadencoderz_filt #(.BITS(32), .QUAD_TYPE(0), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z),
        .indexenable(indexenable), .cntreset(cntreset), .load(load),
        .preset(preset), .err_clr(err_clr),
        .indexout(indexout), .index_pos(index_pos), .position(position),
        .direction(direction), .quad_err(quad_err)
    );

    quadencoderz_filt #(.BITS(8), .QUAD_TYPE(2), .FILTER_LEN(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z),
        .indexenable(indexenable), .cntreset(cntreset), .load(load),
        .preset(preset8), .err_clr(err_clr),
        .indexout(indexout8), .index_pos(index_pos8), .position(position8),
        .direction(direction8), .quad_err(quad_err8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(req_cnt);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "position",   position,   e.pos);
                chk(e.name, "position8",  position8,  e.pos8);
                chk(e.name, "direction",  direction,  e.dir);
                chk(e.name, "direction8", direction8, e.dir);
                chk(e.name, "quad_err",   quad_err,   e.err);
                chk(e.name, "quad_err8",  quad_err8,  e.err);
                chk(e.name, "indexout",   indexout,   e.iout);
                chk(e.name, "indexout8",  indexout8,  e.iout);
                chk(e.name, "index_pos",  index_pos,  e.ipos);
                chk(e.name, "index_pos8", index_pos8, e.ipos8);
            end
        end
    end

    task automatic expect_st(input string nm, input longint p, input longint p8, input bit d,
                             input bit e, input bit io, input longint ip, input longint ip8);
        exp_t x;
        x.name = nm; x.pos = p; x.pos8 = p8; x.dir = d; x.err = e;
        x.iout = io; x.ipos = ip; x.ipos8 = ip8;
        sb.push_back(x);
        req_cnt++;
        #1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic quad_step(input bit dir_up);
        ph = dir_up ? (ph + 1) % 4 : (ph + 3) % 4;
        {a, b} = phase_ab[ph];
        wait_neg(20);
    endtask

    task automatic z_pulse();
        z = 1'b1;
        wait_neg(20);
        z = 1'b0;
        wait_neg(20);
    endtask

    task automatic load_pulse(input logic signed [31:0] v, input logic signed [7:0] v8);
        preset = v;
        preset8 = v8;
        load = 1'b1;
        wait_neg(1);
        load = 1'b0;
        wait_neg(1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        wait_neg(3);
        expect_st("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        wait_neg(2);

        // First A rise: count moves on the 7th edge after the first sampling edge.
        ph = 1;
        {a, b} = phase_ab[ph];
        wait_neg(6);
        expect_st("lat_edge6", 0, 0, 0, 0, 0, 0, 0);
        wait_neg(1);
        expect_st("lat_edge7", 1, 0, 1, 0, 0, 0, 0);
        wait_neg(13);
        for (int i = 0; i < 9; i++) quad_step(1'b1);
        expect_st("ten_up", 10, 2, 1, 0, 0, 0, 0);

        // 3-cycle glitch on A (pins at 11)
        a = 1'b0;
        wait_neg(3);
        a = 1'b1;
        wait_neg(20);
        expect_st("glitch", 10, 2, 1, 0, 0, 0, 0);

        // A and B toggled together
        {a, b} = 2'b00;
        ph = 0;
        wait_neg(20);
        expect_st("err_set", 10, 2, 1, 1, 0, 0, 0);
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
        wait_neg(1);
        expect_st("err_clr", 10, 2, 1, 0, 0, 0, 0);

        // Index capture with count reset at count=37
        for (int i = 0; i < 27; i++) quad_step(1'b1);
        expect_st("count37", 37, 9, 1, 0, 0, 0, 0);
        indexenable = 1'b1;
        cntreset = 1'b1;
        wait_neg(2);
        expect_st("armed", 37, 9, 1, 0, 1, 0, 0);
        z_pulse();
        expect_st("captured", 0, 0, 1, 0, 0, 37, 9);
        z_pulse();
        expect_st("second_z", 0, 0, 1, 0, 0, 37, 9);
        indexenable = 1'b0;
        wait_neg(2);
        expect_st("disarm", 0, 0, 1, 0, 0, 37, 9);
        indexenable = 1'b1;
        wait_neg(2);
        expect_st("rearm", 0, 0, 1, 0, 1, 37, 9);
        indexenable = 1'b0;
        cntreset = 1'b0;
        wait_neg(2);
        expect_st("idle_again", 0, 0, 1, 0, 0, 37, 9);

        // Load of -1 on the same edge as an up-step: the step is discarded.
        preset = -1;
        preset8 = -1;
        ph = (ph + 1) % 4;
        {a, b} = phase_ab[ph];
        wait_neg(6);
        load = 1'b1;
        wait_neg(1);
        load = 1'b0;
        wait_neg(13);
        expect_st("load_vs_step", -1, -1, 1, 0, 0, 37, 9);
        quad_step(1'b1);
        expect_st("wrap_to_0", 0, 0, 1, 0, 0, 37, 9);

        load_pulse(127, 127);
        expect_st("load127", 127, 31, 1, 0, 0, 37, 9);
        quad_step(1'b1);
        expect_st("wrap8", 128, -32, 1, 0, 0, 37, 9);

        // Down-steps and x1 resolution on the 8-bit instance
        load_pulse(0, 0);
        for (int i = 0; i < 8; i++) quad_step(1'b0);
        expect_st("down8", -8, -2, 0, 0, 0, 37, 9);

        // Capture without count reset
        indexenable = 1'b1;
        wait_neg(2);
        expect_st("armed2", -8, -2, 0, 0, 1, 37, 9);
        z_pulse();
        expect_st("cap_noreset", -8, -2, 0, 0, 0, -8, -2);
        quad_step(1'b1);
        quad_step(1'b1);
        expect_st("after_cap", -6, -2, 1, 0, 0, -8, -2);
        indexenable = 1'b0;
        wait_neg(2);

        // Return pins to 00 with an error on the way, then arm at count 55.
        while (ph != 0) quad_step(1'b1);
        {a, b} = 2'b11;
        ph = 2;
        wait_neg(20);
        quad_step(1'b1);
        quad_step(1'b1);
        load_pulse(55, 55);
        indexenable = 1'b1;
        wait_neg(2);
        expect_st("pre_reset", 55, 13, 1, 1, 1, -8, -2);

        #2 rst_n = 1'b0;
        #1;
        expect_st("async_reset", 0, 0, 0, 0, 0, 0, 0);
        indexenable = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(10);
        expect_st("post_reset", 0, 0, 0, 0, 0, 0, 0);
        indexenable = 1'b1;
        wait_neg(2);
        expect_st("rearm_reset", 0, 0, 0, 0, 1, 0, 0);

        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quadencoderz_filt.md
Name: quadencoderz_filt

Overview:
Next-generation quadrature encoder counter with index (Z) support, for the same plugin family as the existing index encoder.
- Adds per-input synchroniser plus configurable glitch filter.
- Adds an explicit index-arming state machine, latching of count at index, and preset load.
- Adds illegal-transition detection with a sticky error flag.
- Sits between the encoder input pins and the host-interface registers.

Parameters:
- BITS, 32: width of internal count, position, index_pos and preset.
- QUAD_TYPE, 0: arithmetic right shift applied to count to form position. 0 = x4, 1 = x2, 2 = x1 resolution.
- FILTER_LEN, 4: cycles a synchronised input must stay stable before it is accepted. Legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- a  in  1  encoder channel A (asynchronous pin)
- b  in  1  encoder channel B (asynchronous pin)
- z  in  1  encoder index (asynchronous pin)
- indexenable  in  1  host request to arm index capture
- cntreset  in  1  when 1, a captured index also zeroes count
- load  in  1  single-cycle strobe: count := preset
- preset  in  BITS  signed load value
- err_clr  in  1  clears the sticky error flag
- indexout  out  1  1 while index capture is armed
- index_pos  out  BITS  signed position latched at the last index event
- position  out  BITS  signed, equals count >>> QUAD_TYPE
- direction  out  1  direction of the last accepted step (1 = up)
- quad_err  out  1  sticky illegal-transition flag

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following clear to 0 immediately, regardless of clk:
  - sync flops, filter counters, filtered A/B/Z and their previous-value registers
  - count, index_pos, indexout, direction, quad_err
  - index FSM returns to IDLE
- Input conditioning, per input:
  - Two-flop synchroniser, then filter counter fcnt.
  - If sync == filt: fcnt := 0.
  - Else if fcnt == FILTER_LEN-1: filt := sync, fcnt := 0.
  - Else: fcnt := fcnt+1.
  - Pulses shorter than FILTER_LEN cycles after synchronisation are rejected.
- Step decode, on filtered A/B against their previous-cycle values (Ap, Bp):
  - step = (A^Ap) xor (B^Bp).
  - up = A ^ Bp, so A leading B counts up.
  - err_evt = (A^Ap) and (B^Bp): both channels changed in one cycle. Produces no step.
- Latency: a stable pin change moves position 3+FILTER_LEN clk edges after the first sampling edge.
- Count update priority, in one cycle:
  1. load: count := preset; any step that cycle is discarded.
  2. Else index reset (capture with cntreset=1): count := 0 ±1 if step, else 0.
  3. Else step: count := count ±1.
  - Wraps modulo 2^BITS (two's complement), no saturation.
- direction updates only on an accepted step. load does not change it.
- quad_err:
  - Set by err_evt; set wins over err_clr in the same cycle.
  - Otherwise cleared by err_clr.
- Index FSM, zrise = filtered Z rising edge (Z=1, Zp=0):
  - IDLE (indexout=0): indexenable=1 -> ARMED.
  - ARMED (indexout=1):
    - indexenable=0 -> IDLE.
    - zrise -> CAPTURED. index_pos := position value before this cycle's update; if cntreset=1, apply the count reset above.
  - CAPTURED (indexout=0): indexenable=0 -> IDLE. Further zrise events are ignored.
  - Outputs indexout are registered and follow the state with one cycle delay after the transition condition.
  - zrise and indexenable falling in the same cycle while ARMED: the capture wins (-> CAPTURED).
- Reset asserted mid-capture: everything clears to its reset value and the FSM returns to IDLE. A capture already performed is not retained.

Decomposition:
- Shared package quadenc_pkg:
  - Index FSM state enum: IDLE, ARMED, CAPTURED.
  - Constants QUAD_X4=0, QUAD_X2=1, QUAD_X1=2.
  - Filter counter width constant FILT_W=8.
- Sub-module quadenc_filter: synchroniser plus glitch filter, parameter FILTER_LEN, ports clk, rst_n, din, dout. Instantiated three times, for A, B and Z.

Test Plan:
- Filter and latency: FILTER_LEN=4; drive 10 clean x4 up-steps (A leads B, 20 cycles per phase) -> position=10 and direction=1. First increment appears exactly 7 edges after the first A rise.
- Glitch and error rejection: 3-cycle pulse on A -> count unchanged. A and B toggled on the same cycle -> quad_err=1, count unchanged. Pulse err_clr -> quad_err=0.
- Index with reset: count=37, indexenable=1, cntreset=1, Z pulse -> indexout 1->0, index_pos=37, count=0. A second Z pulse -> no change. Drop indexenable -> FSM back to IDLE.
- Priority and wrap: load with preset=-1 coincident with an up-step -> count=-1. Next up-step -> 0. With BITS=8, preset=127 plus one up-step -> count=-128.
- Resolution: QUAD_TYPE=2; 8 down-steps from 0 -> position=-2. Index capture without cntreset -> count continues and index_pos holds the captured value.
- Asynchronous reset: assert rst_n=0 mid-stream while ARMED with count=55 -> all outputs read 0 before the next clk edge. After release, the FSM re-arms only on indexenable.
